// File: rtl/axi_write.sv
// axi_write: AXI4 INCR burst writer fed from a stream FIFO.
// Each group of AW_LIN beats lands in the next 1 KiB slot of a 64-slot ring.
module axi_write #(
  parameter int AW_FLIP_BYTE  = 0,
  parameter int AW_ADDR_WIDTH = 32,
  parameter int AW_DATA_WIDTH = 64,
  parameter int AW_LIN        = 16,
  parameter int FIFO_DEPTH    = 32
) (
  input  logic                       m_axi_aclk,
  input  logic                       m_axi_areset,
  input  logic [AW_DATA_WIDTH-1:0]   S_WR_tdata,
  input  logic                       S_WR_tvalid,
  output logic                       S_WR_tready,
  output logic                       m_axi_awid,
  output logic [AW_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awlock,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic [3:0]                 m_axi_awqos,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [AW_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AW_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic                       m_axi_bid,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  output logic                       o_wr_done,
  output logic                       o_wr_err
);

  localparam int SW = AW_DATA_WIDTH / 8;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] LAST = 8'(AW_LIN - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] NEED = CW'(AW_LIN);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    WR_DONE
  } state_t;

  state_t                   state;
  logic [7:0]               beat;
  logic [5:0]               slot_idx;
  logic [AW_DATA_WIDTH-1:0] din;
  logic [AW_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  logic                     push;
  logic                     pop;
  logic                     unused_ok;

  assign m_axi_awid    = 1'b0;
  assign m_axi_awlen   = LAST;
  assign m_axi_awsize  = 3'($clog2(SW));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd3;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wstrb   = '1;
  assign unused_ok     = ^{m_axi_bid, m_axi_bresp[0]};

  generate
    if (AW_FLIP_BYTE != 0) begin : g_flip
      for (genvar i = 0; i < SW; i++) begin : g_b
        assign din[i*8 +: 8] =
          S_WR_tdata[(SW-1-i)*8 +: 8];
      end
    end else begin : g_pass
      assign din = S_WR_tdata;
    end
  endgenerate

  assign S_WR_tready = !m_axi_areset &&
                       (count != FULL);
  assign push = S_WR_tvalid && S_WR_tready;
  assign pop  = m_axi_wvalid && m_axi_wready;

  assign m_axi_wdata = mem[rd_ptr];

  always_ff @(posedge m_axi_aclk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A burst starts only once a whole burst is buffered, so W never starves.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state         <= IDLE;
      beat          <= '0;
      slot_idx      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wlast   <= 1'b0;
      m_axi_bready  <= 1'b0;
      o_wr_done     <= 1'b0;
      o_wr_err      <= 1'b0;
    end else begin
      o_wr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (count >= NEED) begin
            m_axi_awaddr  <=
              AW_ADDR_WIDTH'({slot_idx, 10'd0});
            m_axi_awvalid <= 1'b1;
            state         <= WR_ADDR;
          end
        end
        WR_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wlast   <= (LAST == 8'd0);
            beat          <= '0;
            state         <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (m_axi_wready) begin
            if (m_axi_wlast) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              beat         <= '0;
              m_axi_bready <= 1'b1;
              state        <= WR_RESP;
            end else begin
              beat        <= beat + 8'd1;
              m_axi_wlast <= (beat + 8'd1 == LAST);
            end
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp[1]) o_wr_err <= 1'b1;
            o_wr_done    <= 1'b1;
            state        <= WR_DONE;
          end
        end
        WR_DONE: begin
          slot_idx <= (slot_idx == 6'd63) ?
                      6'd0 : slot_idx + 6'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
